// File: rtl/ucode_sequencer.sv
// Expands one decoded instruction (start address + follow-on count) into a run of
// micro-op issue slots, holding the instruction word and branch sideband throughout.
module ucode_sequencer #(
    parameter int                ADDR_W   = 8,
    parameter int                CNT_W    = 3,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] NOP_ADDR = {ADDR_W{1'b1}}
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_pipeline,
    input  logic               in_valid,
    input  logic [ADDR_W-1:0]  micro_code_addr_in,
    input  logic [CNT_W-1:0]   micro_code_cnt_in,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic               branch_prediction_result_in,
    input  logic [7:0]         branch_instr_address_in,
    input  logic [7:0]         instr_address_not_taken_in,
    output logic               seq_ready,
    input  logic               cu_ready,
    output logic               uop_valid,
    output logic [ADDR_W-1:0]  uop_addr,
    output logic [CNT_W-1:0]   uop_step,
    output logic               uop_last,
    output logic [INSTR_W-1:0] uop_instr,
    output logic               uop_branch_pred,
    output logic [7:0]         uop_branch_addr,
    output logic [7:0]         uop_not_taken_addr
);

    typedef enum logic [1:0] {IDLE, MULTI, LAST} state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   rem, rem_nx, step_nx;
    logic [ADDR_W-1:0]  addr_nx;
    logic [INSTR_W-1:0] instr_nx;
    logic               bp_nx;
    logic [7:0]         ba_nx, nta_nx;
    logic               accept;

    // A new instruction may enter only when no slot survives this edge.
    assign seq_ready = !rst && !flush_pipeline &&
                       (state == IDLE || (state == LAST && cu_ready));
    assign accept    = in_valid && seq_ready;
    assign uop_valid = (state != IDLE);
    assign uop_last  = (state == LAST);

    always_comb begin
        state_nx = state;
        rem_nx   = rem;
        step_nx  = uop_step;
        addr_nx  = uop_addr;
        instr_nx = uop_instr;
        bp_nx    = uop_branch_pred;
        ba_nx    = uop_branch_addr;
        nta_nx   = uop_not_taken_addr;
        if (flush_pipeline) begin
            state_nx = IDLE;
        end else if (accept) begin
            if (micro_code_addr_in == NOP_ADDR) begin
                state_nx = IDLE;
            end else begin
                addr_nx  = micro_code_addr_in;
                step_nx  = '0;
                rem_nx   = micro_code_cnt_in;
                instr_nx = instr_in;
                bp_nx    = branch_prediction_result_in;
                ba_nx    = branch_instr_address_in;
                nta_nx   = instr_address_not_taken_in;
                state_nx = (micro_code_cnt_in == '0) ? LAST : MULTI;
            end
        end else if (cu_ready) begin
            case (state)
                MULTI: begin
                    // Address wraps freely; NOP_ADDR is only special at the input.
                    addr_nx  = uop_addr + ADDR_W'(1);
                    step_nx  = uop_step + CNT_W'(1);
                    rem_nx   = rem - CNT_W'(1);
                    state_nx = (rem == CNT_W'(1)) ? LAST : MULTI;
                end
                LAST:    state_nx = IDLE;
                default: state_nx = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            rem                <= '0;
            uop_step           <= '0;
            uop_addr           <= '0;
            uop_instr          <= '0;
            uop_branch_pred    <= 1'b0;
            uop_branch_addr    <= '0;
            uop_not_taken_addr <= '0;
        end else begin
            state              <= state_nx;
            rem                <= rem_nx;
            uop_step           <= step_nx;
            uop_addr           <= addr_nx;
            uop_instr          <= instr_nx;
            uop_branch_pred    <= bp_nx;
            uop_branch_addr    <= ba_nx;
            uop_not_taken_addr <= nta_nx;
        end
    end

endmodule

// File: tb/tb_ucode_sequencer.sv
// Bench for ucode_sequencer: a queue of pending micro-ops serves as the reference.
module tb_ucode_sequencer;

    logic        clk = 1'b0;
    logic        rst, flush_pipeline, in_valid, cu_ready;
    logic [7:0]  micro_code_addr_in;
    logic [2:0]  micro_code_cnt_in;
    logic [31:0] instr_in;
    logic        branch_prediction_result_in;
    logic [7:0]  branch_instr_address_in, instr_address_not_taken_in;
    logic        seq_ready, uop_valid, uop_last, uop_branch_pred;
    logic [7:0]  uop_addr, uop_branch_addr, uop_not_taken_addr;
    logic [2:0]  uop_step;
    logic [31:0] uop_instr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ucode_sequencer dut (
        .clk(clk), .rst(rst), .flush_pipeline(flush_pipeline), .in_valid(in_valid),
        .micro_code_addr_in(micro_code_addr_in), .micro_code_cnt_in(micro_code_cnt_in),
        .instr_in(instr_in), .branch_prediction_result_in(branch_prediction_result_in),
        .branch_instr_address_in(branch_instr_address_in),
        .instr_address_not_taken_in(instr_address_not_taken_in),
        .seq_ready(seq_ready), .cu_ready(cu_ready), .uop_valid(uop_valid),
        .uop_addr(uop_addr), .uop_step(uop_step), .uop_last(uop_last),
        .uop_instr(uop_instr), .uop_branch_pred(uop_branch_pred),
        .uop_branch_addr(uop_branch_addr), .uop_not_taken_addr(uop_not_taken_addr)
    );

    typedef struct packed {
        logic [7:0]  a;
        logic [2:0]  s;
        logic        l;
        logic [31:0] i;
        logic        bp;
        logic [7:0]  ba;
        logic [7:0]  nta;
    } uop_t;

    // Model: list of micro-ops still owed to the execute stage, front = current slot.
    uop_t mq[$];

    function automatic logic exp_ready();
        return !rst && !flush_pipeline &&
               (mq.size() == 0 || (mq.size() == 1 && cu_ready));
    endfunction

    function automatic logic [62:0] exp_vec();
        return {exp_ready(), mq.size() > 0, (mq.size() > 0) ? mq[0] : 61'd0};
    endfunction

    function automatic logic [62:0] obs_vec();
        uop_t o;
        o = '{uop_addr, uop_step, uop_last, uop_instr, uop_branch_pred,
              uop_branch_addr, uop_not_taken_addr};
        return {seq_ready, uop_valid, uop_valid ? o : 61'd0};
    endfunction

    // Drive one cycle of inputs; word and sideband are fresh random values every cycle.
    task automatic set_in(input logic r, input logic fl, input logic v,
                          input logic [7:0] a, input logic [2:0] c, input logic cr);
        rst = r; flush_pipeline = fl; in_valid = v;
        micro_code_addr_in = a; micro_code_cnt_in = c; cu_ready = cr;
        instr_in = $urandom;
        branch_prediction_result_in = 1'($urandom);
        branch_instr_address_in = 8'($urandom);
        instr_address_not_taken_in = 8'($urandom);
        #1;
    endtask

    // Apply the clock edge to the model, then move to the next sampling point.
    task automatic tick();
        logic acc;
        acc = in_valid && exp_ready();
        if (rst || flush_pipeline) begin
            mq.delete();
        end else begin
            if (cu_ready && mq.size() > 0) void'(mq.pop_front());
            if (acc && micro_code_addr_in != 8'hFF)
                for (int k = 0; k <= int'(micro_code_cnt_in); k++)
                    mq.push_back('{micro_code_addr_in + 8'(k), 3'(k),
                                   k == int'(micro_code_cnt_in), instr_in,
                                   branch_prediction_result_in, branch_instr_address_in,
                                   instr_address_not_taken_in});
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            set_in(1'b1, 1'b0, 1'b1, 8'h05, 3'd1, 1'b1);
            if (c > 0) begin
                checks++;
                if ({seq_ready, uop_valid, uop_addr, uop_step, uop_last, uop_instr,
                     uop_branch_pred, uop_branch_addr, uop_not_taken_addr} !== 63'd0) begin
                    errors++;
                    $display("FAIL reset_outputs cyc %0d: rdy=%b vld=%b addr=%h step=%0d instr=%h, want all 0",
                             c, seq_ready, uop_valid, uop_addr, uop_step, uop_instr);
                end
            end
            tick();
        end
        set_in(1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1);
        checks++;
        if (seq_ready !== 1'b1 || uop_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: rdy=%b vld=%b, want rdy=1 vld=0", seq_ready, uop_valid);
        end
    endtask

    // Directed script: each row is one cycle of {flush, valid, addr, cnt, cu_ready}.
    task automatic run_script(input string name, input logic [14:0] rows[]);
        foreach (rows[n]) begin
            set_in(1'b0, rows[n][14], rows[n][13], rows[n][12:5], rows[n][4:2], rows[n][0]);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL %s cyc %0d: got %h want %h", name, n, obs_vec(), exp_vec());
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [14:0] r[] = '{{2'b01, 8'h00, 3'd0, 2'b01}, {2'b01, 8'h01, 3'd0, 2'b01},
                             {2'b01, 8'h02, 3'd0, 2'b01}, {2'b00, 8'h00, 3'd0, 2'b01},
                             {2'b00, 8'h00, 3'd0, 2'b01}};
        run_script("back_to_back", r);
    endtask

    task automatic test_multi_stall();
        logic [14:0] r[] = '{{2'b01, 8'h07, 3'd2, 2'b01}, {2'b01, 8'h20, 3'd0, 2'b01},
                             {2'b01, 8'h20, 3'd0, 2'b00}, {2'b01, 8'h20, 3'd0, 2'b00},
                             {2'b01, 8'h20, 3'd0, 2'b00}, {2'b01, 8'h20, 3'd0, 2'b01},
                             {2'b01, 8'h20, 3'd0, 2'b01}, {2'b00, 8'h00, 3'd0, 2'b01},
                             {2'b00, 8'h00, 3'd0, 2'b01}};
        run_script("multi_stall", r);
    endtask

    task automatic test_bubble();
        logic [14:0] r[] = '{{2'b01, 8'h10, 3'd0, 2'b01}, {2'b01, 8'hFF, 3'd0, 2'b01},
                             {2'b01, 8'h11, 3'd0, 2'b01}, {2'b00, 8'h00, 3'd0, 2'b01},
                             {2'b00, 8'h00, 3'd0, 2'b01}};
        run_script("bubble", r);
    endtask

    task automatic test_flush();
        logic [14:0] r[] = '{{2'b01, 8'h3A, 3'd2, 2'b01}, {2'b00, 8'h00, 3'd0, 2'b01},
                             {2'b11, 8'h50, 3'd0, 2'b01}, {2'b01, 8'h50, 3'd0, 2'b01},
                             {2'b00, 8'h00, 3'd0, 2'b01}, {2'b00, 8'h00, 3'd0, 2'b01}};
        run_script("flush", r);
    endtask

    task automatic test_wrap_max();
        set_in(1'b0, 1'b0, 1'b1, 8'hFE, 3'd7, 1'b1);
        tick();
        for (int k = 0; k < 8; k++) begin
            set_in(1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1);
            checks++;
            if (uop_valid !== 1'b1 || uop_addr !== 8'(8'hFE + k) || uop_step !== 3'(k) ||
                uop_last !== (k == 7)) begin
                errors++;
                $display("FAIL wrap_max k=%0d: vld=%b addr=%h step=%0d last=%b want 1/%h/%0d/%b",
                         k, uop_valid, uop_addr, uop_step, uop_last, 8'(8'hFE + k), k, k == 7);
            end
            tick();
        end
        set_in(1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1);
        checks++;
        if (uop_valid !== 1'b0) begin
            errors++;
            $display("FAIL wrap_max_end: vld=%b want 0", uop_valid);
        end
    endtask

    task automatic test_random();
        logic [7:0] a;
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 7))
                0:       a = 8'hFF;
                1:       a = 8'hFE;
                default: a = 8'($urandom);
            endcase
            set_in($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 5,
                   1'($urandom), a, 3'($urandom), $urandom_range(0, 3) != 0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc %0d: got %h want %h", n, obs_vec(), exp_vec());
            end
            tick();
        end
    endtask

    initial begin
        set_in(1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0);
        test_reset();
        tick();
        test_back_to_back();
        test_multi_stall();
        test_bubble();
        test_flush();
        test_wrap_max();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ucode_sequencer.md
# ucode_sequencer

Control-unit front end between the instruction decoder and the microcode ROM / execute stage. Accepts one decoded instruction, given as a start address plus a follow-on count, and expands it into a sequence of micro-op issue slots with addresses addr, addr+1, …, addr+cnt, one per accepted cycle. It back-pressures the decoder while a sequence is in progress, drops bubble instructions (address 0xFF), and aborts on pipeline flush. Instruction word and branch-prediction sideband are held stable for the whole sequence.

## Interface
- ADDR_W, 8: microcode address width
- CNT_W, 3: follow-on count width (max sequence length 2^CNT_W)
- INSTR_W, 32: instruction word width
- NOP_ADDR, 8'hFF: bubble address, never issued
- clk  in  1  sole clock, rising edge
- rst  in  1  reset, synchronous, active-high
- flush_pipeline  in  1  abort the current sequence, discard input this cycle
- in_valid  in  1  decoder presents an instruction
- micro_code_addr_in  in  ADDR_W  first micro-op address
- micro_code_cnt_in  in  CNT_W  number of micro-ops following the first
- instr_in  in  INSTR_W  instruction word
- branch_prediction_result_in  in  1  predicted taken
- branch_instr_address_in  in  8  branch target
- instr_address_not_taken_in  in  8  fall-through address
- seq_ready  out  1  instruction accepted this cycle when in_valid is also high
- cu_ready  in  1  downstream consumes the current micro-op
- uop_valid  out  1  micro-op slot valid
- uop_addr  out  ADDR_W  micro-op address
- uop_step  out  CNT_W  index within sequence, 0 = first
- uop_last  out  1  final micro-op of the instruction
- uop_instr  out  INSTR_W  held instruction word
- uop_branch_pred, uop_branch_addr[7:0], uop_not_taken_addr[7:0]  out  held sideband

## Operation
- States: IDLE (no valid slot), MULTI (valid, remaining > 0), LAST (valid, remaining = 0).
- Accept = in_valid & seq_ready. seq_ready = !rst & !flush_pipeline & (state==IDLE | (state==LAST & cu_ready)).
- Accept with addr != NOP_ADDR: load uop_addr=addr, uop_step=0, remaining=cnt, latch instr and sideband. Next state is LAST if cnt==0, otherwise MULTI.
- Accept with addr == NOP_ADDR: the instruction is consumed and nothing is issued. Next state is IDLE, or stays unchanged if no slot was retiring; in practice the next state is IDLE.
- MULTI & cu_ready: uop_addr += 1 (mod 2^ADDR_W, no skip of NOP_ADDR mid-sequence), uop_step += 1, remaining -= 1. Goes to LAST when remaining becomes 0.
- MULTI/LAST & !cu_ready: all outputs hold.
- LAST & cu_ready & no accept: go to IDLE.
- LAST & cu_ready & accept: load the new instruction directly. This is back-to-back with no bubble.
- uop_last = (state==LAST).
- flush_pipeline: next state IDLE, uop_valid=0, no accept. Flush has priority over cu_ready and in_valid.

## Timing
- All outputs except seq_ready are registered. seq_ready is combinational from state, cu_ready, flush_pipeline and rst.
- Latency: an instruction accepted at edge N shows uop_valid=1, step 0 after edge N.
- Sequence of cnt+1 micro-ops needs at least cnt+1 cycles. The next instruction is accepted on the edge that retires the last micro-op.
- Sustained throughput with cu_ready=1: 1 micro-op per cycle; single-micro-op instructions issue 1 per cycle.
- Reset, synchronous, priority over flush: state=IDLE, uop_valid=0, uop_addr=0, uop_step=0, uop_last=0, uop_instr=0, all sideband=0. seq_ready=0 while rst is high.
- Reset or flush mid-sequence: the remaining micro-ops are discarded and none are issued afterward.
- cnt = 2^CNT_W−1 (7): 8 micro-ops, uop_step reaches 7 without overflow.
- Address wrap: addr=0xFE, cnt=2 issues 0xFE, 0xFF, 0x00.

## Test plan
- Reset: hold rst 2 cycles, in_valid=1 → uop_valid=0 and seq_ready=0 throughout. One cycle after release → seq_ready=1.
- Single ops back-to-back: addr 0x00, 0x01, 0x02, all cnt=0, cu_ready=1 → uop_addr 0x00, 0x01, 0x02 on consecutive cycles, uop_last=1 each, seq_ready stays 1.
- Multi op with stall: addr 0x07, cnt=2, cu_ready low on the 2nd slot for 3 cycles → 0x07 (step 0), 0x08 held 4 cycles, then 0x09 (step 2, last). seq_ready=0 until the edge retiring 0x09. instr and sideband are constant throughout.
- Bubble: addr 0xFF, cnt=0 between two valid ops → accepted, no uop_valid slot for it, following op issues on the next cycle.
- Flush mid-sequence: addr 0x3A, cnt=2, flush asserted while 0x3B is valid → uop_valid=0 next cycle, 0x3C is never issued, new instruction accepted the cycle after flush deasserts.
- Wrap and max count: addr 0xFE, cnt=7 → 0xFE, 0xFF, 0x00 … 0x05, step 0…7, uop_last only on 0x05.
